// File: rtl/voice_allocator_if.sv
// Note-event handshake plus per-voice envelope control bus between a note source and the voice allocator.
interface voice_allocator_if #(
  parameter int unsigned VOICES    = 4,
  parameter int unsigned NOTE_BITS = 7
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_on;
  logic [NOTE_BITS-1:0]          in_note;
  logic [VOICES-1:0]             active;
  logic [VOICES-1:0]             gate;
  logic [VOICES*NOTE_BITS-1:0]   voice_note;
  logic                          steal;

  modport master (
    output in_valid, in_on, in_note, active,
    input  in_ready, gate, voice_note, steal
  );

  modport slave (
    input  in_valid, in_on, in_note, active,
    output in_ready, gate, voice_note, steal
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto ADSR voices using
// retrigger, free-voice, oldest-released and LRU-steal priority.
module voice_allocator #(
  parameter int unsigned VOICES    = 4,
  parameter int unsigned NOTE_BITS = 7
) (
  input  logic             clk,
  input  logic             reset,
  voice_allocator_if.slave bus
);
  localparam int unsigned IW = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic {IDLE, GAP} state_t;

  state_t               state, state_nx;
  logic [VOICES-1:0]    gate, gate_nx;
  logic [NOTE_BITS-1:0] note    [VOICES];
  logic [NOTE_BITS-1:0] note_nx [VOICES];
  logic [IW-1:0]        rank    [VOICES];
  logic [IW-1:0]        rank_nx [VOICES];
  logic [IW-1:0]        pend, pend_nx;
  logic                 steal, steal_nx;

  logic                 a_found, b_found, c_found;
  logic [IW-1:0]        a_idx, b_idx, c_idx, c_rank, d_idx, sel;
  logic                 retrig, stolen;

  // Voice choice for a note-on; first matching rule wins
  always_comb begin
    a_found = 1'b0; a_idx = '0;
    b_found = 1'b0; b_idx = '0;
    c_found = 1'b0; c_idx = '0; c_rank = '0;
    d_idx   = '0;
    for (int i = 0; i < int'(VOICES); i++) begin
      if (!a_found && gate[i] && note[i] == bus.in_note) begin
        a_found = 1'b1; a_idx = IW'(i);
      end
      if (!b_found && !gate[i] && !bus.active[i]) begin
        b_found = 1'b1; b_idx = IW'(i);
      end
      if (!gate[i] && (!c_found || rank[i] > c_rank)) begin
        c_found = 1'b1; c_idx = IW'(i); c_rank = rank[i];
      end
      if (rank[i] == IW'(VOICES - 1)) d_idx = IW'(i);
    end
    if (a_found) begin
      sel = a_idx; retrig = 1'b1; stolen = 1'b0;
    end else if (b_found) begin
      sel = b_idx; retrig = 1'b0; stolen = 1'b0;
    end else if (c_found) begin
      sel = c_idx; retrig = 1'b0; stolen = 1'b0;
    end else begin
      sel = d_idx; retrig = 1'b1; stolen = 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    gate_nx  = gate;
    note_nx  = note;
    rank_nx  = rank;
    pend_nx  = pend;
    steal_nx = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (!bus.in_on) begin
            for (int i = 0; i < int'(VOICES); i++)
              if (gate[i] && note[i] == bus.in_note) gate_nx[i] = 1'b0;
          end else begin
            note_nx[sel] = bus.in_note;
            for (int j = 0; j < int'(VOICES); j++) begin
              if (IW'(j) == sel)          rank_nx[j] = '0;
              else if (rank[j] < rank[sel]) rank_nx[j] = rank[j] + IW'(1);
            end
            // Retrigger and steal drop the gate for one cycle so the ADSR sees a new rising edge
            if (retrig) begin
              gate_nx[sel] = 1'b0;
              pend_nx      = sel;
              state_nx     = GAP;
              steal_nx     = stolen;
            end else begin
              gate_nx[sel] = 1'b1;
            end
          end
        end
      end
      GAP: begin
        gate_nx[pend] = 1'b1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gate  <= '0;
      pend  <= '0;
      steal <= 1'b0;
      for (int i = 0; i < int'(VOICES); i++) begin
        note[i] <= '0;
        rank[i] <= IW'(i);
      end
    end else begin
      state <= state_nx;
      gate  <= gate_nx;
      pend  <= pend_nx;
      steal <= steal_nx;
      note  <= note_nx;
      rank  <= rank_nx;
    end
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.gate     = gate;
  assign bus.steal    = steal;

  for (genvar g = 0; g < int'(VOICES); g++) begin : g_pack
    assign bus.voice_note[g*NOTE_BITS +: NOTE_BITS] = note[g];
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed vector table, reset-in-gap
// sequence and randomized traffic against an LRU-list reference model.
module tb_voice_allocator;
  localparam int V  = 4;
  localparam int NB = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  voice_allocator_if #(.VOICES(V), .NOTE_BITS(NB)) bus ();
  voice_allocator #(.VOICES(V), .NOTE_BITS(NB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: lru[0] is the most recently allocated voice, lru[$] the oldest
  bit m_gate [V];
  int m_note [V];
  int lru    [$];
  bit m_gap;
  int m_pend;
  bit m_steal;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [V-1:0] m_gate_vec();
    logic [V-1:0] r;
    for (int i = 0; i < V; i++) r[i] = m_gate[i];
    return r;
  endfunction

  function automatic logic [V*NB-1:0] m_note_vec();
    logic [V*NB-1:0] r;
    for (int i = 0; i < V; i++) r[i*NB +: NB] = NB'(m_note[i]);
    return r;
  endfunction

  function automatic logic [V*NB-1:0] pk(input int n0, input int n1, input int n2, input int n3);
    return {NB'(n3), NB'(n2), NB'(n1), NB'(n0)};
  endfunction

  task automatic model_reset();
    lru.delete();
    for (int i = 0; i < V; i++) begin
      m_gate[i] = 1'b0;
      m_note[i] = 0;
      lru.push_back(i);
    end
    m_gap = 1'b0; m_pend = 0; m_steal = 1'b0;
  endtask

  task automatic model_step(input bit iv, input bit ion, input int inote, input logic [V-1:0] iact);
    int v;
    bit regate;
    m_steal = 1'b0;
    if (m_gap) begin
      m_gate[m_pend] = 1'b1;
      m_gap = 1'b0;
    end else if (iv && !ion) begin
      for (int i = 0; i < V; i++)
        if (m_gate[i] && m_note[i] == inote) m_gate[i] = 1'b0;
    end else if (iv) begin
      v = -1; regate = 1'b0;
      for (int i = 0; i < V; i++)
        if (v < 0 && m_gate[i] && m_note[i] == inote) begin v = i; regate = 1'b1; end
      for (int i = 0; i < V; i++)
        if (v < 0 && !m_gate[i] && !iact[i]) v = i;
      for (int k = lru.size() - 1; k >= 0; k--)
        if (v < 0 && !m_gate[lru[k]]) v = lru[k];
      if (v < 0) begin v = lru[$]; regate = 1'b1; m_steal = 1'b1; end
      for (int k = 0; k < lru.size(); k++)
        if (lru[k] == v) begin lru.delete(k); break; end
      lru.push_front(v);
      m_note[v] = inote;
      if (regate) begin
        m_gate[v] = 1'b0; m_gap = 1'b1; m_pend = v;
      end else begin
        m_gate[v] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gate"},       64'(bus.gate),       64'(m_gate_vec()));
    chk({tag, ".voice_note"}, 64'(bus.voice_note), 64'(m_note_vec()));
    chk({tag, ".steal"},      64'(bus.steal),      64'(m_steal));
    chk({tag, ".in_ready"},   64'(bus.in_ready),   64'(!m_gap));
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge
  task automatic cyc(input bit iv, input bit ion, input int inote, input logic [V-1:0] iact, input string tag);
    bus.in_valid = iv;
    bus.in_on    = ion;
    bus.in_note  = NB'(inote);
    bus.active   = iact;
    model_step(iv, ion, inote, iact);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit              v;
    bit              on;
    int              note;
    logic [V-1:0]    act;
    logic [V-1:0]    g;
    logic [V*NB-1:0] vn;
    bit              st;
    bit              rdy;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int ev_on, ev_note;
    bit ev_v;
    logic [V-1:0] ev_act;

    bus.in_valid = 1'b0;
    bus.in_on    = 1'b0;
    bus.in_note  = '0;
    bus.active   = '0;
    model_reset();

    tbl[0]  = '{1, 1, 60, 4'b0000, 4'b0001, pk(60, 0, 0, 0),    0, 1};
    tbl[1]  = '{1, 1, 62, 4'b0000, 4'b0011, pk(60, 62, 0, 0),   0, 1};
    tbl[2]  = '{1, 1, 64, 4'b0000, 4'b0111, pk(60, 62, 64, 0),  0, 1};
    tbl[3]  = '{1, 1, 65, 4'b0000, 4'b1111, pk(60, 62, 64, 65), 0, 1};
    tbl[4]  = '{1, 0, 62, 4'b0000, 4'b1101, pk(60, 62, 64, 65), 0, 1};
    tbl[5]  = '{1, 1, 67, 4'b0010, 4'b1111, pk(60, 67, 64, 65), 0, 1};
    tbl[6]  = '{1, 1, 70, 4'b0000, 4'b1110, pk(70, 67, 64, 65), 1, 0};
    tbl[7]  = '{0, 0, 0,  4'b0000, 4'b1111, pk(70, 67, 64, 65), 0, 1};
    tbl[8]  = '{1, 1, 64, 4'b0000, 4'b1011, pk(70, 67, 64, 65), 0, 0};
    tbl[9]  = '{0, 0, 0,  4'b0000, 4'b1111, pk(70, 67, 64, 65), 0, 1};
    tbl[10] = '{1, 0, 99, 4'b0000, 4'b1111, pk(70, 67, 64, 65), 0, 1};
    tbl[11] = '{1, 1, 70, 4'b0000, 4'b1110, pk(70, 67, 64, 65), 0, 0};
    tbl[12] = '{1, 0, 67, 4'b0000, 4'b1111, pk(70, 67, 64, 65), 0, 1};
    tbl[13] = '{1, 0, 67, 4'b0000, 4'b1101, pk(70, 67, 64, 65), 0, 1};

    // Reset state
    @(posedge clk);
    #1;
    chk("reset.gate",       64'(bus.gate),       64'(0));
    chk("reset.voice_note", 64'(bus.voice_note), 64'(0));
    chk("reset.steal",      64'(bus.steal),      64'(0));
    chk("reset.in_ready",   64'(bus.in_ready),   64'(1));
    reset = 1'b0;

    // Directed vectors, including held valid across a gap cycle
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].v, tbl[i].on, tbl[i].note, tbl[i].act, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_gate", i),  64'(bus.gate),       64'(tbl[i].g));
      chk($sformatf("vec%0d.tbl_notes", i), 64'(bus.voice_note), 64'(tbl[i].vn));
      chk($sformatf("vec%0d.tbl_steal", i), 64'(bus.steal),      64'(tbl[i].st));
      chk($sformatf("vec%0d.tbl_ready", i), 64'(bus.in_ready),   64'(tbl[i].rdy));
    end

    // Reset during a retrigger gap aborts the pending gate
    cyc(1, 1, 64, 4'b0000, "gap_enter");
    chk("gap_enter.gate", 64'(bus.gate), 64'(4'b1001));
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_gap.gate",     64'(bus.gate),     64'(0));
    chk("rst_gap.in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    chk("rst_gap.hold_gate", 64'(bus.gate), 64'(0));
    reset = 1'b0;
    model_reset();

    // First edge after release accepts; all voices active so rank order decides (voice 3 oldest)
    cyc(1, 1, 50, 4'b1111, "post_rst");
    chk("post_rst.gate", 64'(bus.gate), 64'(4'b1000));
    cyc(1, 1, 51, 4'b1111, "post_rst2");
    chk("post_rst2.gate", 64'(bus.gate), 64'(4'b1100));
    cyc(0, 0, 0, 4'b0000, "idle");

    // Randomized traffic; an offered event is held until the model accepts it
    ev_v = 1'b0; ev_on = 0; ev_note = 60; ev_act = '0;
    for (int n = 0; n < 600; n++) begin
      bit accepted;
      accepted = ev_v && !m_gap;
      if (!ev_v || accepted || ($urandom_range(0, 7) == 0)) begin
        ev_v    = ($urandom_range(0, 3) != 0);
        ev_on   = ($urandom_range(0, 2) != 0) ? 1 : 0;
        ev_note = int'($urandom_range(60, 67));
        ev_act  = V'($urandom_range(0, 15));
      end
      cyc(ev_v, ev_on[0], ev_note, ev_act, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 The module SHALL have parameter VOICES, default 4, giving the number of ADSR envelope voices managed (2..16).
REQ-002 The module SHALL have parameter NOTE_BITS, default 7, giving the note number width.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  note event offered this cycle.
REQ-006 Port in_ready  output  1  allocator can accept an event this cycle.
REQ-007 Port in_on  input  1  1 = note-on, 0 = note-off; sampled with in_valid.
REQ-008 Port in_note  input  NOTE_BITS  note number; sampled with in_valid.
REQ-009 Port active  input  VOICES  per-voice ADSR active flags, bit i from voice i's envelope.
REQ-010 Port gate  output  VOICES  registered per-voice gate to each ADSR.
REQ-011 Port voice_note  output  VOICES*NOTE_BITS  registered note held by each voice; voice i at bits [i*NOTE_BITS +: NOTE_BITS].
REQ-012 Port steal  output  1  one-cycle pulse when a gated voice is taken for a new note.

Function
REQ-013 An event SHALL be accepted in a cycle where in_valid and in_ready are both 1; gate and voice_note SHALL reflect it on the next rising edge (latency 1).
REQ-014 The FSM SHALL have states IDLE (in_ready=1) and GAP (in_ready=0).
REQ-015 Note-off SHALL clear gate[i] for every voice with gate[i]=1 and a matching voice_note; with no match it SHALL be accepted and ignored; the FSM stays IDLE.
REQ-016 Note-on voice choice SHALL use this priority, first match wins: (a) gated voice holding the same note; (b) lowest-index voice with gate=0 and active=0; (c) oldest voice with gate=0; (d) oldest voice overall.
REQ-017 Choice (b) or (c) SHALL set voice_note[v]=in_note and gate[v]=1 on the next edge, FSM stays IDLE.
REQ-018 Choice (a) or (d) SHALL, on the next edge, set gate[v]=0, set voice_note[v]=in_note, and enter GAP; on the following edge gate[v]=1 and the FSM returns to IDLE, giving the ADSR a fresh rising gate edge.
REQ-019 steal SHALL pulse 1 for exactly the cycle after acceptance under choice (d) only; choice (a) is a retrigger, not a steal.
REQ-020 Age SHALL be an LRU rank per voice, 0 = newest, VOICES-1 = oldest, always a permutation of 0..VOICES-1.
REQ-021 On every note-on allocation, the chosen voice's rank SHALL become 0 and every voice with a lower prior rank SHALL increment by 1; others unchanged. Note-off SHALL NOT change ranks.
REQ-022 "Oldest" in (c) SHALL mean the highest rank among gate=0 voices; in (d) the voice with rank VOICES-1.
REQ-023 In GAP, in_valid SHALL be ignored and no state other than the pending gate SHALL change.
REQ-024 active SHALL only influence choice (b); it SHALL have no effect on gate directly.

Reset
REQ-025 While reset=1: gate=0, voice_note=0 for all voices, steal=0, FSM=IDLE, in_ready=1 after release, rank[i]=i.
REQ-026 Reset asserted during GAP SHALL abort the retrigger; gate[v] stays 0 after release.
REQ-027 The first edge after reset release SHALL be able to accept an event.

Verification
REQ-028 After reset, note-on 60, 62, 64, 65 with active=0 -> gate=4'b1111, voice 0..3 notes 60,62,64,65, steal never 1.
REQ-029 Then note-off 62 -> next cycle gate=4'b1101; with active[1]=1 held, note-on 67 -> voice 1 reused via choice (c), gate=4'b1111, voice_note[1]=67, steal=0.
REQ-030 All four gated (notes 60,67,64,65), note-on 70 -> voice 0 (rank 3): gate[0]=0 and steal=1 one cycle, in_ready=0 that cycle, gate[0]=1 next, voice_note[0]=70.
REQ-031 Note-on 64 while voice 2 gated with 64 -> gate[2] 1->0->1 across two edges, steal=0, voice 2 rank becomes 0.
REQ-032 in_valid held high with alternating events -> no event lost; events offered during GAP accepted only after in_ready returns to 1.
REQ-033 Reset asserted in GAP cycle -> gate=0, rank[i]=i, in_ready=1 after release; note-off for an unheld note -> no output change.
